// File: rtl/rx_sync_pkg.sv
// Shared types and constants for the receive-side sync controller.
package rx_sync_pkg;

  typedef enum logic [1:0] {
    LOSS_OF_SYNC = 2'd0,
    COMMA_DET    = 2'd1,
    SYNC_ACQ     = 2'd2,
    SYNC_ERR     = 2'd3
  } sync_state_e;

  localparam logic [7:0] K28_1 = 8'h3C;
  localparam logic [7:0] K28_5 = 8'hBC;
  localparam logic [7:0] K28_7 = 8'hFC;

  // Comma pattern only; validity of the code group is qualified by the caller.
  function automatic logic is_comma(input logic [7:0] data, input logic k);
    return k && ((data == K28_1) || (data == K28_5) || (data == K28_7));
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear (clear has priority).
module sat_counter #(
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] cnt
);

  logic [W-1:0] cnt_d, cnt_q;

  // Next count: clear wins, otherwise increment unless already all-ones.
  always_comb begin
    cnt_d = cnt_q;
    if (clr)
      cnt_d = '0;
    else if (inc && (cnt_q != '1))
      cnt_d = cnt_q + 1'b1;
  end

  // Counter register, asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) cnt_q <= '0;
    else      cnt_q <= cnt_d;
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/rx_sync_ctrl.sv
// Comma-based acquire/lose-sync controller with error hysteresis, gated
// data forwarding and a saturating code-violation counter.
module rx_sync_ctrl
  import rx_sync_pkg::*;
#(
  parameter int unsigned ACQ_COMMAS = 3,
  parameter int unsigned ERR_MAX    = 4,
  parameter int unsigned GOOD_RUN   = 4,
  parameter int unsigned CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [7:0]       in_data,
  input  logic             in_k,
  input  logic             in_invalid,
  input  logic             cnt_clr,
  output logic             sync_ok,
  output logic             out_valid,
  output logic [7:0]       out_data,
  output logic             out_k,
  output logic             lost_sync,
  output logic [2:0]       err_level,
  output logic [CNT_W-1:0] code_err_cnt
);

  localparam int unsigned CC_W = $clog2(ACQ_COMMAS + 1);
  localparam int unsigned GC_W = $clog2(GOOD_RUN + 1);
  localparam logic [CC_W-1:0] ACQ_L  = CC_W'(ACQ_COMMAS);
  localparam logic [GC_W-1:0] GOOD_L = GC_W'(GOOD_RUN);
  localparam logic [2:0]      ERR_L  = 3'(ERR_MAX);

  sync_state_e     state_d, state_q;
  logic [CC_W-1:0] comma_cnt_d, comma_cnt_q, comma_inc;
  logic [GC_W-1:0] good_cnt_d, good_cnt_q, good_inc;
  logic [2:0]      err_lvl_d, err_lvl_q, err_inc;
  logic            lost_d, lost_q;
  logic            out_valid_d, out_valid_q;
  logic [7:0]      out_data_d, out_data_q;
  logic            out_k_d, out_k_q;
  logic            comma, in_sync;

  // An invalid code group never counts as a comma, whatever its pattern.
  assign comma     = is_comma(in_data, in_k) && !in_invalid;
  assign in_sync   = (state_q == SYNC_ACQ) || (state_q == SYNC_ERR);
  assign comma_inc = comma_cnt_q + 1'b1;
  assign good_inc  = good_cnt_q + 1'b1;
  assign err_inc   = err_lvl_q + 3'd1;

  // Next-state, hysteresis counters and forwarded-word capture.
  always_comb begin
    state_d     = state_q;
    comma_cnt_d = comma_cnt_q;
    good_cnt_d  = good_cnt_q;
    err_lvl_d   = err_lvl_q;
    lost_d      = 1'b0;
    out_valid_d = in_valid && !in_invalid && in_sync;
    out_data_d  = out_data_q;
    out_k_d     = out_k_q;

    if (out_valid_d) begin
      out_data_d = in_data;
      out_k_d    = in_k;
    end

    if (in_valid) begin
      unique case (state_q)
        // LOSS_OF_SYNC and COMMA_DET share the comma-counting path: from
        // LOSS the counter is 0, so one comma may already complete acquisition.
        LOSS_OF_SYNC, COMMA_DET: begin
          if (in_invalid) begin
            state_d     = LOSS_OF_SYNC;
            comma_cnt_d = '0;
          end else if (comma) begin
            if (comma_inc == ACQ_L) begin
              state_d     = SYNC_ACQ;
              comma_cnt_d = '0;
            end else begin
              state_d     = COMMA_DET;
              comma_cnt_d = comma_inc;
            end
          end
        end
        SYNC_ACQ: begin
          if (in_invalid) begin
            state_d    = SYNC_ERR;
            err_lvl_d  = 3'd1;
            good_cnt_d = '0;
          end
        end
        SYNC_ERR: begin
          if (in_invalid) begin
            good_cnt_d = '0;
            if (err_inc == ERR_L) begin
              state_d   = LOSS_OF_SYNC;
              err_lvl_d = '0;
              lost_d    = 1'b1;
            end else begin
              err_lvl_d = err_inc;
            end
          end else if (good_inc == GOOD_L) begin
            good_cnt_d = '0;
            err_lvl_d  = err_lvl_q - 3'd1;
            if (err_lvl_q == 3'd1) state_d = SYNC_ACQ;
          end else begin
            good_cnt_d = good_inc;
          end
        end
        default: state_d = LOSS_OF_SYNC;
      endcase
    end
  end

  // State and output registers, asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= LOSS_OF_SYNC;
      comma_cnt_q <= '0;
      good_cnt_q  <= '0;
      err_lvl_q   <= '0;
      lost_q      <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_k_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      comma_cnt_q <= comma_cnt_d;
      good_cnt_q  <= good_cnt_d;
      err_lvl_q   <= err_lvl_d;
      lost_q      <= lost_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_k_q     <= out_k_d;
    end
  end

  sat_counter #(.W(CNT_W)) u_code_err_cnt (
    .clk (clk),
    .rst (rst),
    .inc (in_valid && in_invalid),
    .clr (cnt_clr),
    .cnt (code_err_cnt)
  );

  assign sync_ok   = in_sync;
  assign err_level = err_lvl_q;
  assign lost_sync = lost_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_k     = out_k_q;

endmodule

// File: tb/tb_rx_sync_ctrl.sv
// Self-checking bench for rx_sync_ctrl: directed scenarios plus random
// traffic, compared every cycle against a behavioural reference model.
module tb_rx_sync_ctrl;

  localparam int ACQ  = 3;
  localparam int EMAX = 4;
  localparam int GRUN = 4;
  localparam int CW   = 4;
  localparam int CMAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid, in_k, in_invalid, cnt_clr;
  logic [7:0]    in_data;
  logic          sync_ok, out_valid, out_k, lost_sync;
  logic [7:0]    out_data;
  logic [2:0]    err_level;
  logic [CW-1:0] code_err_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: "synced" flag plus plain integer counts.
  bit       m_sync;
  int       m_commas, m_err, m_good, m_cnt;
  bit       m_lost, m_ov, m_ok;
  logic [7:0] m_od;

  rx_sync_ctrl #(
    .ACQ_COMMAS (ACQ),
    .ERR_MAX    (EMAX),
    .GOOD_RUN   (GRUN),
    .CNT_W      (CW)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_data      (in_data),
    .in_k         (in_k),
    .in_invalid   (in_invalid),
    .cnt_clr      (cnt_clr),
    .sync_ok      (sync_ok),
    .out_valid    (out_valid),
    .out_data     (out_data),
    .out_k        (out_k),
    .lost_sync    (lost_sync),
    .err_level    (err_level),
    .code_err_cnt (code_err_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_sync = 0; m_commas = 0; m_err = 0; m_good = 0; m_cnt = 0;
    m_lost = 0; m_ov = 0; m_ok = 0; m_od = 8'h00;
  endtask

  task automatic model_step(input bit v, input logic [7:0] d, input bit k,
                            input bit inv, input bit clr);
    bit was_sync;
    bit is_c;
    was_sync = m_sync;
    m_lost   = 0;
    if (clr)                     m_cnt = 0;
    else if (v && inv && m_cnt < CMAX) m_cnt = m_cnt + 1;
    m_ov = v && !inv && was_sync;
    if (m_ov) begin
      m_od = d;
      m_ok = k;
    end
    if (v) begin
      is_c = !inv && k && (d == 8'h3C || d == 8'hBC || d == 8'hFC);
      if (!m_sync) begin
        if (inv) m_commas = 0;
        else if (is_c) begin
          m_commas = m_commas + 1;
          if (m_commas == ACQ) begin
            m_sync = 1; m_commas = 0; m_err = 0; m_good = 0;
          end
        end
      end else if (inv) begin
        m_err  = m_err + 1;
        m_good = 0;
        if (m_err == EMAX) begin
          m_sync = 0; m_err = 0; m_lost = 1;
        end
      end else if (m_err > 0) begin
        m_good = m_good + 1;
        if (m_good == GRUN) begin
          m_err  = m_err - 1;
          m_good = 0;
        end
      end
    end
  endtask

  task automatic check_outputs(input string w);
    chk({w, ".sync_ok"},   32'(sync_ok),      32'(m_sync));
    chk({w, ".err_level"}, 32'(err_level),    32'(m_err));
    chk({w, ".lost_sync"}, 32'(lost_sync),    32'(m_lost));
    chk({w, ".out_valid"}, 32'(out_valid),    32'(m_ov));
    chk({w, ".out_data"},  32'(out_data),     32'(m_od));
    chk({w, ".out_k"},     32'(out_k),        32'(m_ok));
    chk({w, ".err_cnt"},   32'(code_err_cnt), 32'(m_cnt));
  endtask

  task automatic step(input string w, input bit v, input logic [7:0] d, input bit k,
                      input bit inv, input bit clr);
    in_valid = v; in_data = d; in_k = k; in_invalid = inv; cnt_clr = clr;
    @(posedge clk);
    #1;
    model_step(v, d, k, inv, clr);
    check_outputs(w);
  endtask

  task automatic acquire(input string w);
    for (int i = 0; i < ACQ; i++) begin
      step(w, 1, 8'hBC, 1, 0, 0);
      if (i < ACQ - 1) step(w, 1, 8'h4A, 0, 0, 0);
    end
  endtask

  initial begin
    rst = 1'b0;
    in_valid = 0; in_data = '0; in_k = 0; in_invalid = 0; cnt_clr = 0;
    model_reset();
    #12;
    check_outputs("reset");
    @(negedge clk);
    rst = 1'b1;

    // Acquisition: comma / D-word alternation, then first forwarded word.
    acquire("acq");
    chk("acq_sync_ok", 32'(sync_ok), 32'd1);
    step("fwd", 1, 8'h55, 0, 0, 0);
    chk("fwd_valid", 32'(out_valid), 32'd1);
    chk("fwd_data",  32'(out_data),  32'h55);

    // Four invalids back-to-back: levels 1,2,3 then loss.
    step("clr", 0, 8'h00, 0, 0, 1);
    for (int i = 1; i <= 4; i++) begin
      step("errs", 1, 8'hBC, 1, 1, 0);
      if (i < 4) chk("errs_level", 32'(err_level), 32'(i));
    end
    chk("loss_pulse",   32'(lost_sync),    32'd1);
    chk("loss_sync_ok", 32'(sync_ok),      32'd0);
    chk("loss_cnt",     32'(code_err_cnt), 32'd4);
    step("post_loss", 1, 8'h11, 0, 0, 0);
    chk("loss_pulse_end", 32'(lost_sync), 32'd0);

    // Invalid word aborts comma detection; a fresh set is needed.
    step("cd", 1, 8'hBC, 1, 0, 0);
    step("cd", 1, 8'h3C, 1, 0, 0);
    step("cd_inv", 1, 8'h00, 0, 1, 0);
    chk("cd_abort", 32'(sync_ok), 32'd0);
    step("cd", 1, 8'hFC, 1, 0, 0);
    step("cd", 1, 8'hBC, 1, 0, 0);
    chk("cd_two_only", 32'(sync_ok), 32'd0);
    step("cd", 1, 8'hBC, 1, 0, 0);
    chk("cd_resync", 32'(sync_ok), 32'd1);

    // One invalid then a good run recovers to level 0.
    step("hyst_inv", 1, 8'h77, 0, 1, 0);
    for (int i = 0; i < GRUN; i++) step("hyst_good", 1, 8'(8'h20 + i), i[0], 0, 0);
    chk("hyst_level", 32'(err_level), 32'd0);
    chk("hyst_sync",  32'(sync_ok),   32'd1);

    // Saturation of the violation counter, then clear beats a same-cycle error.
    for (int i = 0; i < 16; i++) step("sat", 1, 8'(i), 0, 1, 0);
    chk("sat_value", 32'(code_err_cnt), 32'hF);
    step("sat_clr", 1, 8'h00, 0, 1, 1);
    chk("sat_cleared", 32'(code_err_cnt), 32'd0);

    // Asynchronous reset in the middle of SYNC_ERR with gaps.
    acquire("rs");
    step("rs_inv", 1, 8'h00, 0, 1, 0);
    step("rs_gap", 0, 8'hBC, 1, 1, 0);
    step("rs_gap", 0, 8'h00, 0, 1, 0);
    step("rs_inv", 1, 8'h00, 0, 1, 0);
    step("rs_good", 1, 8'h99, 0, 0, 0);
    step("rs_gap", 0, 8'h00, 0, 0, 0);
    chk("rs_level", 32'(err_level), 32'd2);
    #2;
    rst = 1'b0;
    #1;
    model_reset();
    check_outputs("async_rst");
    @(posedge clk);
    #1;
    check_outputs("rst_held");
    @(negedge clk);
    rst = 1'b1;

    // Randomized traffic.
    for (int n = 0; n < 3000; n++) begin
      bit v, k, inv, clr;
      logic [7:0] d;
      int sel;
      v   = ($urandom % 10) != 0;
      sel = $urandom % 100;
      clr = ($urandom % 60) == 0;
      d   = 8'($urandom);
      k   = ($urandom % 8) == 0;
      inv = 0;
      if (sel < 30) begin
        k = 1;
        case ($urandom % 3)
          0: d = 8'h3C;
          1: d = 8'hBC;
          default: d = 8'hFC;
        endcase
        inv = ($urandom % 10) == 0;
      end else if (sel < 42) begin
        inv = 1;
      end
      step("rnd", v, d, k, inv, clr);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
